// File: rtl/shift_if.sv
// Handshake and operand/result bundle between a shift requester and shift_controller.
interface shift_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  ready;
   logic [1:0]            shiftType;
   logic [7:0]            shiftAmt;
   logic [DATA_WIDTH-1:0] rmData;
   logic                  carryIn;
   logic [DATA_WIDTH-1:0] result;
   logic                  carryOut;
   logic                  done;

   modport master (
      output start, shiftType, shiftAmt, rmData, carryIn,
      input  ready, result, carryOut, done
   );

   modport slave (
      input  start, shiftType, shiftAmt, rmData, carryIn,
      output ready, result, carryOut, done
   );
endinterface

// File: rtl/shift_controller.sv
// Multi-cycle barrel-shift replacement: performs an LSL/LSR/ASR/ROR one bit per cycle
// with ARM-style register-specified amount and carry-out semantics.
module shift_controller #(
   parameter int DATA_WIDTH = 32
) (
   input logic    clk,
   input logic    reset,
   shift_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [5:0]            count, count_n;
   logic [DATA_WIDTH-1:0] work, work_n;
   logic                  carry, carry_n;
   logic [1:0]            type_q, type_n;
   logic                  zero_q, zero_n;
   logic                  done_q, ready_q;

   always_comb begin
      state_n = state;
      count_n = count;
      work_n  = work;
      carry_n = carry;
      type_n  = type_q;
      zero_n  = zero_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               type_n = bus.shiftType;
               work_n = bus.rmData;
               zero_n = 1'b0;
               if (bus.shiftAmt == 8'd0) begin
                  carry_n = bus.carryIn;
                  state_n = DONE;
               end else if (bus.shiftType == 2'b11 && bus.shiftAmt[4:0] == 5'd0) begin
                  carry_n = bus.rmData[DATA_WIDTH-1];
                  state_n = DONE;
               end else begin
                  if (bus.shiftType == 2'b11)
                     count_n = {1'b0, bus.shiftAmt[4:0]};
                  else if (bus.shiftAmt > 8'd32)
                     count_n = 6'd32;
                  else
                     count_n = bus.shiftAmt[5:0];
                  // Logical shifts past 32 still run 32 steps; only the final carry differs.
                  zero_n  = (bus.shiftType[1] == 1'b0) && (bus.shiftAmt > 8'd32);
                  state_n = SHIFT;
               end
            end
         end
         SHIFT: begin
            case (type_q)
               2'b00: begin
                  carry_n = work[DATA_WIDTH-1];
                  work_n  = {work[DATA_WIDTH-2:0], 1'b0};
               end
               2'b01: begin
                  carry_n = work[0];
                  work_n  = {1'b0, work[DATA_WIDTH-1:1]};
               end
               2'b10: begin
                  carry_n = work[0];
                  work_n  = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
               end
               default: begin
                  carry_n = work[0];
                  work_n  = {work[0], work[DATA_WIDTH-1:1]};
               end
            endcase
            count_n = count - 6'd1;
            if (count == 6'd1) begin
               state_n = DONE;
               if (zero_q)
                  carry_n = 1'b0;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         work    <= '0;
         carry   <= 1'b0;
         type_q  <= '0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         count   <= count_n;
         work    <= work_n;
         carry   <= carry_n;
         type_q  <= type_n;
         zero_q  <= zero_n;
         done_q  <= (state_n == DONE);
         ready_q <= (state_n == IDLE);
      end
   end

   assign bus.result   = work;
   assign bus.carryOut = carry;
   assign bus.done     = done_q;
   assign bus.ready    = ready_q;

endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, as the operand/result width; only the value 32 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a shift; accepted only when ready=1.
REQ-005 The module SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-006 The module SHALL have port shiftType, input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 The module SHALL have port shiftAmt, input, 8 bits: register-specified shift amount (Rs[7:0]).
REQ-008 The module SHALL have port rmData, input, 32 bits: operand to shift.
REQ-009 The module SHALL have port carryIn, input, 1 bit: current C flag.
REQ-010 The module SHALL have port result, output, 32 bits: shifted operand.
REQ-011 The module SHALL have port carryOut, output, 1 bit: shifter carry-out.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 Accept SHALL occur on a rising edge where start=1 and state=IDLE; on accept, shiftType, shiftAmt, rmData and carryIn SHALL be captured, and later input changes SHALL have no effect until the next accept.
REQ-015 start SHALL be ignored in SHIFT and DONE, with no queueing.
REQ-016 Step count N SHALL be: for LSL/LSR/ASR, min(shiftAmt,32); for ROR, shiftAmt[4:0].
REQ-017 If shiftAmt=0 (any type), accept SHALL go to DONE with result=rmData and carryOut=carryIn.
REQ-018 If shiftType=ROR, shiftAmt!=0 and shiftAmt[4:0]=0, accept SHALL go to DONE with result=rmData and carryOut=rmData[31].
REQ-019 Otherwise, accept SHALL go to SHIFT with the counter loaded to N and the working register loaded with rmData.
REQ-020 In SHIFT, each cycle SHALL perform exactly one 1-bit step and decrement the counter.
REQ-021 Per-step rules SHALL be:
- LSL: shift left, carry = old bit31
- LSR: shift right zero-fill, carry = old bit0
- ASR: shift right sign-fill, carry = old bit0
- ROR: rotate right, bit0 goes to bit31 and carry = old bit0
REQ-022 The step that brings the counter to 0 SHALL transition to DONE.
REQ-023 For LSL/LSR with shiftAmt>32, the final carryOut SHALL be forced to 0 and result SHALL be 0.
REQ-024 For ASR with shiftAmt>=32, result SHALL be all copies of bit31 and carryOut SHALL equal bit31.
REQ-025 Latency: numbering the accept cycle as cycle 0, done SHALL be high in exactly cycle N+1 (N=0 for REQ-017/018), for one cycle.
REQ-026 DONE SHALL always return to IDLE on the next edge; ready SHALL be high from cycle N+2.
REQ-027 result and carryOut SHALL be valid while done=1 and SHALL hold stable until the next accept.
REQ-028 Intermediate values on result during SHIFT are don't-care to consumers.
REQ-029 The block SHALL contain no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-030 When reset=1 at a rising edge, on that edge the state SHALL become IDLE, result=0, carryOut=0, done=0, counter=0 and ready=1.
REQ-031 Reset SHALL take priority over start and over any in-progress SHIFT or DONE; an aborted operation SHALL produce no done pulse.
REQ-032 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-033 The bench SHALL cover: LSL, shiftAmt=4, rmData=0x8000_000F, carryIn=0 -> result=0x0000_00F0, carryOut=0, done in cycle 5.
REQ-034 The bench SHALL cover: LSR, shiftAmt=0, rmData=0xDEAD_BEEF, carryIn=1 -> result=0xDEAD_BEEF, carryOut=1, done in cycle 1, ready in cycle 2.
REQ-035 The bench SHALL cover: ASR, shiftAmt=40, rmData=0x8000_0000 -> result=0xFFFF_FFFF, carryOut=1, done in cycle 33.
REQ-036 The bench SHALL cover LSL/LSR boundaries: LSR, shiftAmt=32, rmData=0x8000_0001 -> result=0, carryOut=1, done in cycle 33; then LSL, shiftAmt=33, rmData=0xFFFF_FFFF -> result=0, carryOut=0, done in cycle 33.
REQ-037 The bench SHALL cover ROR: ROR, shiftAmt=8, rmData=0x1234_5678 -> result=0x7812_3456, carryOut=0, done in cycle 9; then ROR, shiftAmt=32, rmData=0x8000_0000 -> result=0x8000_0000, carryOut=1, done in cycle 1.
REQ-038 The bench SHALL cover reset and busy behaviour: LSL, shiftAmt=20 accepted; start pulsed in cycle 3 with new operands; reset=1 in cycle 5 -> no second accept occurs, cycle 6 shows ready=1, done=0, result=0, carryOut=0, and no done pulse occurs afterwards.
